// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch/decode encodings: next-PC command codes, the NOP filler word,
// the fetch FSM states and the buffer entry layout.
package if_fetch_unit_pkg;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INST_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_WAIT,
    ST_DISCARD
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic npc_op_valid(input logic [2:0] op);
    return (op == NPC_BRANCH) || (op == NPC_JUMP) || (op == NPC_JALR);
  endfunction

  function automatic logic [31:0] npc_target(input logic [2:0]  op,
                                             input logic [31:0] pc,
                                             input logic [31:0] imm,
                                             input logic [31:0] rs1);
    logic [31:0] t;
    t = (op == NPC_JALR) ? ((rs1 + imm) & ~32'd1) : (pc + imm);
    return {t[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch unit bus bundle: imem request/response, execute redirect and decode handoff.
// master = fetch unit side, slave = memory/execute/decode side.
interface if_fetch_unit_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [2:0]  redirect_op;
  logic [31:0] redirect_pc;
  logic [31:0] redirect_imm;
  logic [31:0] redirect_rs1;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_pc, id_inst,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_op, redirect_pc, redirect_imm, redirect_rs1,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_inst,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_op, redirect_pc, redirect_imm, redirect_rs1,
    output id_ready
  );

endinterface

// File: rtl/if_fetch_unit_fetch_buf.sv
// Generic synchronous FIFO with push/pop/flush, used as the fetch buffer.
// Latency: push visible at head the cycle after the write edge; head is combinational.
// Backpressure: caller must not push when full unless popping the same cycle.
module fetch_buf #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW:0]      cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: head is only looked at while the count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_dat;
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = cnt_q;
  assign full     = (cnt_q == FULL_CNT);
  assign empty    = (cnt_q == '0);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC register, single-outstanding imem port, fetch buffer to decode.
// Latency: redirect to target inst on id_* = 1 request cycle + memory latency + 1 cycle.
// Backpressure: id_ready low fills the buffer; requests stop once buffer + outstanding is full.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INST  = NOP_INST_WORD
) (
  input logic             clk,
  input logic             rstn,
  if_fetch_unit_if.master bus
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(BUF_DEPTH);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  wait_pc_q;
  logic         req_vld_q;

  logic         redir;
  logic [31:0]  target;
  logic         req_acc;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  logic         fetch_next;
  logic [CW-1:0] count;
  logic [CW-1:0] cnt_d;
  fetch_entry_t push_ent;
  fetch_entry_t head_ent;

  assign redir   = bus.redirect_valid && npc_op_valid(bus.redirect_op);
  assign target  = npc_target(bus.redirect_op, bus.redirect_pc, bus.redirect_imm, bus.redirect_rs1);
  assign req_acc = req_vld_q && bus.imem_req_ready;

  // A response that lands together with a redirect belongs to the squashed path.
  assign push = (state_q == ST_WAIT) && bus.imem_rsp_valid && !redir && (!full || pop);
  assign pop  = bus.id_ready && !empty && !redir;

  assign push_ent.pc   = wait_pc_q;
  assign push_ent.inst = bus.imem_rsp_data;

  always_comb begin
    cnt_d = count;
    if (redir)              cnt_d = '0;
    else if (push && !pop)  cnt_d = count + 1'b1;
    else if (pop && !push)  cnt_d = count - 1'b1;
  end

  // Either staying in FETCH without a hand-off, or the outstanding response returning now.
  assign fetch_next = ((state_q == ST_FETCH) && !req_acc) ||
                      ((state_q != ST_FETCH) && bus.imem_rsp_valid);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      wait_pc_q <= RESET_PC;
      req_vld_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (req_acc) begin
            wait_pc_q <= pc_q;
            state_q   <= redir ? ST_DISCARD : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rsp_valid) state_q <= ST_FETCH;
          else if (redir)         state_q <= ST_DISCARD;
        end
        ST_DISCARD: begin
          if (bus.imem_rsp_valid) state_q <= ST_FETCH;
        end
        default: state_q <= ST_FETCH;
      endcase

      if (redir)        pc_q <= target;
      else if (req_acc) pc_q <= pc_q + 32'd4;

      req_vld_q <= fetch_next && (cnt_d < DEPTH_CNT);
    end
  end

  fetch_buf #(
    .DEPTH (BUF_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fetch_buf (
    .clk      (clk),
    .rstn     (rstn),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .flush    (redir),
    .head_dat (head_ent),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  assign bus.imem_req_valid = req_vld_q;
  assign bus.imem_req_addr  = pc_q;
  assign bus.id_valid       = !empty;
  assign bus.id_pc          = empty ? 32'd0 : head_ent.pc;
  assign bus.id_inst        = empty ? NOP_INST : head_ent.inst;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a small in-order imem responder of adjustable latency.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  if_fetch_unit_if bus();

  if_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2),
    .NOP_INST  (32'h0000_0013)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          lat = 1;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One clock: memory sees the pre-edge handshake, inputs change 1ns after the edge.
  task automatic step();
    logic        acc;
    logic [31:0] a;
    acc = bus.imem_req_valid && bus.imem_req_ready;
    a   = bus.imem_req_addr;
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    if (acc) begin
      pend      = 1'b1;
      pend_cnt  = lat;
      pend_addr = a;
    end
    if (pend) begin
      if (pend_cnt <= 1) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(pend_addr);
        pend               = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
  endtask

  task automatic do_reset();
    rstn               = 1'b0;
    pend               = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_op    = NPC_PLUS4;
    bus.redirect_pc    = '0;
    bus.redirect_imm   = '0;
    bus.redirect_rs1   = '0;
    bus.id_ready       = 1'b1;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic redirect(input logic [2:0] op, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [31:0] rs1);
    bus.redirect_valid = 1'b1;
    bus.redirect_op    = op;
    bus.redirect_pc    = pc;
    bus.redirect_imm   = imm;
    bus.redirect_rs1   = rs1;
    step();
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_inst);
    int n;
    n = 0;
    while (!bus.id_valid && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_vld"}, {31'd0, bus.id_valid}, 32'd1);
    if (bus.id_valid) begin
      chk({tag, "_pc"}, bus.id_pc, exp_pc);
      chk({tag, "_inst"}, bus.id_inst, exp_inst);
    end
    bus.id_ready = 1'b1;
    step();
  endtask

  task automatic wait_accept(input string tag);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      seen = bus.imem_req_valid && bus.imem_req_ready;
      step();
    end
    chk({tag, "_acc"}, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    // Reset values, then sequential fetch at latency 1
    do_reset();
    rstn = 1'b0;
    #1;
    chk("rst_req_vld", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("rst_req_addr", bus.imem_req_addr, 32'h0000_0000);
    chk("rst_id_vld", {31'd0, bus.id_valid}, 32'd0);
    chk("rst_id_pc", bus.id_pc, 32'h0000_0000);
    chk("rst_id_inst", bus.id_inst, 32'h0000_0013);
    rstn = 1'b1;
    step();
    chk("t1_first_req_vld", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("t1_first_req_addr", bus.imem_req_addr, 32'h0000_0000);
    pop_expect("t1_0", 32'h0000_0000, 32'h5A5A_0000);
    pop_expect("t1_4", 32'h0000_0004, 32'h5A5A_0004);
    pop_expect("t1_8", 32'h0000_0008, 32'h5A5A_0008);
    pop_expect("t1_c", 32'h0000_000C, 32'h5A5A_000C);

    // Decode stall fills the buffer and stops requests
    do_reset();
    bus.id_ready = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("t2_full_vld", {31'd0, bus.id_valid}, 32'd1);
    chk("t2_hold_pc", bus.id_pc, 32'h0000_0000);
    chk("t2_req_off", {31'd0, bus.imem_req_valid}, 32'd0);
    pop_expect("t2_0", 32'h0000_0000, 32'h5A5A_0000);
    pop_expect("t2_4", 32'h0000_0004, 32'h5A5A_0004);
    pop_expect("t2_8", 32'h0000_0008, 32'h5A5A_0008);

    // Branch while waiting on memory drops the in-flight response
    do_reset();
    lat = 3;
    wait_accept("t3");
    redirect(NPC_BRANCH, 32'h0000_0010, 32'hFFFF_FFF8, 32'h0);
    chk("t3_flush_vld", {31'd0, bus.id_valid}, 32'd0);
    pop_expect("t3_tgt", 32'h0000_0008, 32'h5A5A_0008);
    pop_expect("t3_next", 32'h0000_000C, 32'h5A5A_000C);

    // JALR clears low bits, JUMP is pc-relative, unknown op is ignored
    lat = 1;
    redirect(NPC_JALR, 32'h0000_0500, 32'h0000_0004, 32'h0000_1003);
    pop_expect("t4_jalr", 32'h0000_1004, 32'h5A5A_1004);
    redirect(NPC_JUMP, 32'h0000_0040, 32'h0000_0020, 32'h0000_0000);
    pop_expect("t4_jump", 32'h0000_0060, 32'h5A5A_0060);
    redirect(3'b011, 32'h0000_0200, 32'h0000_0100, 32'h0000_0000);
    pop_expect("t4_badop", 32'h0000_0064, 32'h5A5A_0064);

    // PC wraps past the top of the address space; address holds while not accepted
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    redirect(NPC_JUMP, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000);
    for (int i = 0; i < 3; i++) begin
      chk("t5_hold_vld", {31'd0, bus.imem_req_valid}, 32'd1);
      chk("t5_hold_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
      step();
    end
    bus.imem_req_ready = 1'b1;
    pop_expect("t5_top", 32'hFFFF_FFFC, 32'hA5A5_FFFC);
    pop_expect("t5_wrap", 32'h0000_0000, 32'h5A5A_0000);

    // Async reset mid-WAIT with an entry buffered; the stale response must not land
    do_reset();
    lat = 3;
    bus.id_ready = 1'b0;
    wait_accept("t6a");
    wait_accept("t6b");
    chk("t6_pre_vld", {31'd0, bus.id_valid}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("t6_rst_req_vld", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("t6_rst_req_addr", bus.imem_req_addr, 32'h0000_0000);
    chk("t6_rst_id_vld", {31'd0, bus.id_valid}, 32'd0);
    chk("t6_rst_id_pc", bus.id_pc, 32'h0000_0000);
    chk("t6_rst_id_inst", bus.id_inst, 32'h0000_0013);
    step();
    rstn = 1'b1;
    bus.id_ready = 1'b1;
    pop_expect("t6_restart", 32'h0000_0000, 32'h5A5A_0000);
    pop_expect("t6_next", 32'h0000_0004, 32'h5A5A_0004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
